pool_ctrl: RTL and testbench



---
 rtl/pool_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pool_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pool_ctrl
// Purpose  : Job sequencer for the pool unit: latches a job configuration,
//            meters rows into pool, waits for completion, reports status.
//            Optional DRAIN watchdog: define POOL_CTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pool_ctrl #(
  parameter int DWIDTH        = 16,
  parameter int DESIGN_SIZE   = 16,
  parameter int MAX_BITS_POOL = 3,
  parameter int MASK_WIDTH    = 16,
  parameter int TIMEOUT       = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          cfg_enable_pool,
  input  logic [MAX_BITS_POOL-1:0]      cfg_window_size,
  input  logic [4:0]                    cfg_num_rows,
  input  logic [4:0]                    cfg_valid_cols,
  input  logic                          src_data_valid,
  input  logic [DESIGN_SIZE*DWIDTH-1:0] src_data,
  output logic                          src_ready,
  output logic                          pool_enable,
  output logic [MAX_BITS_POOL-1:0]      pool_window_size,
  output logic                          pool_in_data_available,
  output logic [DESIGN_SIZE*DWIDTH-1:0] pool_inp_data,
  output logic [MASK_WIDTH-1:0]         pool_validity_mask,
  input  logic                          pool_out_data_available,
  input  logic                          pool_done,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [4:0]                    rows_out
);

  localparam logic [5:0]               C_MAX_ROWS = 6'(DESIGN_SIZE);
  localparam logic [5:0]               C_MAX_COLS = 6'(MASK_WIDTH);
  localparam logic [MAX_BITS_POOL-1:0] C_WIN1     = MAX_BITS_POOL'(1);
  localparam logic [MAX_BITS_POOL-1:0] C_WIN2     = MAX_BITS_POOL'(2);
  localparam logic [MAX_BITS_POOL-1:0] C_WIN4     = MAX_BITS_POOL'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                          state_q, state_d;
  logic                            busy_q, src_ready_q, done_q, error_q;
  logic                            pool_enable_q, in_avail_q;
  logic [MAX_BITS_POOL-1:0]        pool_win_q;
  logic [MASK_WIDTH-1:0]           mask_q;
  logic [DESIGN_SIZE*DWIDTH-1:0]   inp_data_q;
  logic [4:0]                      num_rows_q, row_cnt_q, rows_out_q, rows_out_d;

  logic                            w_legal, w_accept, w_last_row, w_exit, w_timeout;
  logic [MASK_WIDTH-1:0]           w_mask;

  always_comb begin
    w_legal = ((cfg_window_size == C_WIN1) || (cfg_window_size == C_WIN2) ||
               (cfg_window_size == C_WIN4)) &&
              (cfg_num_rows != 5'd0) && ({1'b0, cfg_num_rows} <= C_MAX_ROWS) &&
              (cfg_valid_cols != 5'd0) && ({1'b0, cfg_valid_cols} <= C_MAX_COLS);
    for (int i = 0; i < MASK_WIDTH; i++) begin
      w_mask[i] = (i < int'(cfg_valid_cols));
    end
  end

`ifdef POOL_CTRL_TIMEOUT_EN
  localparam int C_TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [C_TO_W-1:0] to_cnt_q;

  // Held at zero outside DRAIN so every DRAIN entry starts counting from 0.
  always_ff @(posedge clk) begin
    if (reset || (state_q != S_DRAIN)) begin
      to_cnt_q <= '0;
    end else if (!w_timeout) begin
      to_cnt_q <= to_cnt_q + C_TO_W'(1);
    end
  end

  assign w_timeout = (state_q == S_DRAIN) && (to_cnt_q == C_TO_W'(TIMEOUT));
`else
  logic w_timeout_unused;
  assign w_timeout_unused = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_accept   = (state_q == S_FEED) && src_data_valid;
    w_last_row = w_accept && ((row_cnt_q + 5'd1) == num_rows_q);
    rows_out_d = rows_out_q;
    if (pool_out_data_available && ((state_q == S_FEED) || (state_q == S_DRAIN)) &&
        (rows_out_q != 5'd31)) begin
      rows_out_d = rows_out_q + 5'd1;
    end
    // Bypass exit includes a pulse arriving in the same cycle.
    w_exit  = pool_enable_q ? pool_done : (rows_out_d == num_rows_q);
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = w_legal ? S_FEED : S_DONE;
      S_FEED:  if (w_last_row) state_d = S_DRAIN;
      S_DRAIN: if (w_exit || w_timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      src_ready_q   <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      pool_enable_q <= 1'b0;
      in_avail_q    <= 1'b0;
      pool_win_q    <= '0;
      mask_q        <= '0;
      inp_data_q    <= '0;
      num_rows_q    <= '0;
      row_cnt_q     <= '0;
      rows_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d == S_FEED) || (state_d == S_DRAIN);
      src_ready_q <= (state_d == S_FEED);
      done_q      <= (state_d == S_DONE);
      in_avail_q  <= w_accept;
      rows_out_q  <= rows_out_d;
      if (w_accept) begin
        inp_data_q <= src_data;
        row_cnt_q  <= row_cnt_q + 5'd1;
      end
      if ((state_q == S_IDLE) && start) begin
        num_rows_q <= cfg_num_rows;
        row_cnt_q  <= '0;
        rows_out_q <= '0;
        error_q    <= !w_legal;
        if (w_legal) begin
          pool_enable_q <= cfg_enable_pool;
          pool_win_q    <= cfg_window_size;
          mask_q        <= w_mask;
        end
      end
      if ((state_q == S_DRAIN) && !w_exit && w_timeout) begin
        error_q <= 1'b1;
      end
    end
  end

  assign src_ready              = src_ready_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign error                  = error_q;
  assign rows_out               = rows_out_q;
  assign pool_enable            = pool_enable_q;
  assign pool_window_size       = pool_win_q;
  assign pool_validity_mask     = mask_q;
  assign pool_in_data_available = in_avail_q;
  assign pool_inp_data          = inp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_pool_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_ctrl
// Purpose  : Self-checking bench for pool_ctrl: configuration vector table
//            plus directed multi-cycle job sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_ctrl;
  localparam int DW = 16;
  localparam int DS = 16;
  localparam int MB = 3;
  localparam int MW = 16;
  localparam int TO = 255;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           cfg_enable_pool = 1'b0;
  logic [MB-1:0]  cfg_window_size = '0;
  logic [4:0]     cfg_num_rows = '0;
  logic [4:0]     cfg_valid_cols = '0;
  logic           src_data_valid = 1'b0;
  logic [DS*DW-1:0] src_data = '0;
  logic           src_ready, pool_enable, pool_in_data_available;
  logic [MB-1:0]  pool_window_size;
  logic [DS*DW-1:0] pool_inp_data;
  logic [MW-1:0]  pool_validity_mask;
  logic           pool_out_data_available = 1'b0;
  logic           pool_done = 1'b0;
  logic           busy, done, error;
  logic [4:0]     rows_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pool_ctrl #(.DWIDTH(DW), .DESIGN_SIZE(DS), .MAX_BITS_POOL(MB), .MASK_WIDTH(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_enable_pool(cfg_enable_pool),
    .cfg_window_size(cfg_window_size), .cfg_num_rows(cfg_num_rows), .cfg_valid_cols(cfg_valid_cols),
    .src_data_valid(src_data_valid), .src_data(src_data), .src_ready(src_ready),
    .pool_enable(pool_enable), .pool_window_size(pool_window_size),
    .pool_in_data_available(pool_in_data_available), .pool_inp_data(pool_inp_data),
    .pool_validity_mask(pool_validity_mask), .pool_out_data_available(pool_out_data_available),
    .pool_done(pool_done), .busy(busy), .done(done), .error(error), .rows_out(rows_out)
  );

  typedef struct packed {
    logic          en;
    logic [MB-1:0] win;
    logic [4:0]    rows;
    logic [4:0]    cols;
    logic [MW-1:0] exp_mask;
    logic [MB-1:0] exp_win;
    logic          exp_en;
    logic          exp_busy;
    logic          exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DS*DW-1:0] act, input logic [DS*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DS*DW-1:0] row(input int r);
    logic [DS*DW-1:0] v;
    for (int e = 0; e < DS; e++) v[e*DW +: DW] = 16'(r * 256 + e);
    return v;
  endfunction

  function automatic logic [30:0] all_outs();
    return {src_ready, pool_enable, pool_window_size, pool_in_data_available,
            |pool_inp_data, pool_validity_mask, busy, done, error, rows_out};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    src_data_valid = 1'b0;
    pool_done = 1'b0;
    pool_out_data_available = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic start_job(input logic en, input logic [MB-1:0] win, input logic [4:0] rows,
                           input logic [4:0] cols);
    cfg_enable_pool = en;
    cfg_window_size = win;
    cfg_num_rows    = rows;
    cfg_valid_cols  = cols;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [DS*DW-1:0] last;
    int pulses;

    vecs[0]  = '{1'b1, 3'd2, 5'd4,  5'd16, 16'hFFFF, 3'd2, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 3'd1, 5'd1,  5'd1,  16'h0001, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 3'd4, 5'd16, 5'd5,  16'h001F, 3'd4, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 3'd2, 5'd16, 5'd15, 16'h7FFF, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 3'd3, 5'd4,  5'd8,  16'h0000, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 3'd0, 5'd4,  5'd8,  16'h0000, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 3'd2, 5'd0,  5'd8,  16'h0000, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 3'd2, 5'd17, 5'd8,  16'h0000, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 3'd2, 5'd4,  5'd0,  16'h0000, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 3'd2, 5'd4,  5'd17, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 3'd7, 5'd4,  5'd8,  16'h0000, 3'd0, 1'b0, 1'b0, 1'b1};

    do_reset();
    chk("reset_state", 256'(all_outs()), 256'd0);

    // Cycle-1 response to each configuration: {busy,src_ready,done,error,en,win,mask}
    for (int i = 0; i < 11; i++) begin
      do_reset();
      start_job(vecs[i].en, vecs[i].win, vecs[i].rows, vecs[i].cols);
      chk($sformatf("cfg_vec%0d", i),
          256'({busy, src_ready, done, error, pool_enable, pool_window_size, pool_validity_mask}),
          256'({vecs[i].exp_busy, vecs[i].exp_busy, !vecs[i].exp_busy, vecs[i].exp_err,
                vecs[i].exp_en, vecs[i].exp_win, vecs[i].exp_mask}));
    end

    // Basic pooling job, back-to-back rows
    do_reset();
    start_job(1'b1, 3'd2, 5'd4, 5'd16);
    chk("basic_busy_ready", 256'({busy, src_ready}), 256'(2'b11));
    for (int r = 0; r < 4; r++) begin
      src_data_valid = 1'b1;
      src_data = row(r);
      tick();
      chk($sformatf("basic_avail%0d", r), 256'(pool_in_data_available), 256'(1));
      chk($sformatf("basic_data%0d", r), pool_inp_data, row(r));
    end
    src_data_valid = 1'b0;
    chk("basic_drain_ready", 256'({busy, src_ready}), 256'(2'b10));
    tick();
    chk("basic_avail_off", 256'(pool_in_data_available), 256'(0));
    tick();
    pool_done = 1'b1;
    tick();
    pool_done = 1'b0;
    chk("basic_done", 256'({done, error, busy}), 256'(3'b100));
    chk("basic_cfg", 256'({pool_window_size, pool_validity_mask}), 256'({3'd2, 16'hFFFF}));
    chk("basic_hold", pool_inp_data, row(3));

    // Throttled source
    do_reset();
    start_job(1'b1, 3'd1, 5'd3, 5'd8);
    pulses = 0;
    last = '0;
    for (int i = 0; i < 6; i++) begin
      src_data_valid = (i % 2 == 0);
      src_data = row(10 + i);
      if (i % 2 == 0) last = row(10 + i);
      tick();
      chk($sformatf("thr_avail%0d", i), 256'(pool_in_data_available), 256'((i % 2 == 0) ? 1 : 0));
      chk($sformatf("thr_data%0d", i), pool_inp_data, last);
      if (pool_in_data_available) pulses++;
    end
    src_data_valid = 1'b0;
    chk("thr_pulses", 256'(pulses), 256'(3));
    chk("thr_drain", 256'({busy, src_ready}), 256'(2'b10));
    pool_done = 1'b1;
    tick();
    pool_done = 1'b0;
    chk("thr_done", 256'({done, error}), 256'(2'b10));

    // Bypass: completion follows the second out pulse
    do_reset();
    start_job(1'b0, 3'd1, 5'd2, 5'd4);
    for (int r = 0; r < 2; r++) begin
      src_data_valid = 1'b1;
      src_data = row(20 + r);
      tick();
    end
    src_data_valid = 1'b0;
    chk("byp_cfg", 256'({pool_enable, pool_validity_mask}), 256'({1'b0, 16'h000F}));
    pool_out_data_available = 1'b1;
    tick();
    pool_out_data_available = 1'b0;
    tick();
    chk("byp_mid", 256'({done, busy, rows_out}), 256'({1'b0, 1'b1, 5'd1}));
    pool_out_data_available = 1'b1;
    tick();
    pool_out_data_available = 1'b0;
    chk("byp_done", 256'({done, busy, error, rows_out}), 256'({3'b100, 5'd2}));

    // Illegal configurations; error sticky until next start
    do_reset();
    start_job(1'b1, 3'd3, 5'd4, 5'd8);
    chk("ill_win_c1", 256'({done, error, busy, src_ready}), 256'(4'b1100));
    tick();
    chk("ill_win_c2", 256'({done, error, busy, src_ready}), 256'(4'b0100));
    start_job(1'b1, 3'd2, 5'd4, 5'd8);
    chk("err_clear", 256'({error, busy}), 256'(2'b01));
    do_reset();
    start_job(1'b1, 3'd2, 5'd4, 5'd0);
    chk("ill_cols_c1", 256'({done, error, busy, src_ready}), 256'(4'b1100));

    // Reset mid-FEED, then a minimum-length job
    do_reset();
    start_job(1'b1, 3'd2, 5'd4, 5'd16);
    for (int r = 0; r < 2; r++) begin
      src_data_valid = 1'b1;
      src_data = row(30 + r);
      tick();
    end
    src_data_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_outs", 256'(all_outs()), 256'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_no_done%0d", i), 256'({done, busy}), 256'(0));
    end
    start_job(1'b1, 3'd1, 5'd1, 5'd16);
    src_data_valid = 1'b1;
    src_data = row(40);
    tick();
    src_data_valid = 1'b0;
    pool_done = 1'b1;
    chk("min_c2", 256'({done, busy, src_ready}), 256'(3'b010));
    tick();
    pool_done = 1'b0;
    chk("min_c3_done", 256'({done, busy, error}), 256'(3'b100));

`ifdef POOL_CTRL_TIMEOUT_EN
    do_reset();
    start_job(1'b1, 3'd1, 5'd1, 5'd16);
    src_data_valid = 1'b1;
    tick();
    src_data_valid = 1'b0;
    for (int i = 0; i < TO; i++) tick();
    chk("to_before", 256'({done, error, busy}), 256'(3'b001));
    tick();
    chk("to_done", 256'({done, error, busy}), 256'(3'b110));
    tick();
    start_job(1'b1, 3'd1, 5'd1, 5'd16);
    chk("to_err_clear", 256'({error, busy}), 256'(2'b01));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
